vga_timing_gen: RTL and testbench

Parametrised successor to the fixed 640x480 VGA sync block. It generates horizontal and vertical sync, pixel coordinates, an active-video flag and frame/line/pixel strobes for any VESA-style mode. It runs from the system clock through an internal clock-enable divider rather than a derived clock. It sits between the system clock and the pixel/colour generator, which consumes the coordinates and strobes.

---
 rtl/vga_timing_gen.sv | 115 +++++++++++
 tb/tb_vga_timing_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: a clock-enable divider paces pixel steps, and every
// decoded output is registered from the next counter values so none of them skew.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned CW        = 10
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Enable,
  output logic          HorizontalSync,
  output logic          VerticalSync,
  output logic [CW-1:0] HorizontalCounter,
  output logic [CW-1:0] VerticalCounter,
  output logic          ActiveVideo,
  output logic          PixelStrobe,
  output logic          LineStart,
  output logic          FrameStart
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SS     = H_ACTIVE + H_FRONT;
  localparam int unsigned H_SE     = H_SS + H_SYNC;
  localparam int unsigned V_SS     = V_ACTIVE + V_FRONT;
  localparam int unsigned V_SE     = V_SS + V_SYNC;
  localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

  if (CLK_DIV < 1 || (64'd1 << CW) < 64'(H_TOTAL) || (64'd1 << CW) < 64'(V_TOTAL)) begin : g_param_check
    $error("vga_timing_gen: CW too narrow for the raster or CLK_DIV < 1");
  end

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic          hs_q, hs_d, vs_q, vs_d, av_q, av_d;
  logic          ps_q, ps_d, ls_q, ls_d, fs_q, fs_d;
  logic          step, h_wrap;

  always_comb begin
    step   = Enable && (div_q == DIV_LAST);
    h_wrap = (h_q == H_LAST);
    div_d  = div_q;
    h_d    = h_q;
    v_d    = v_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    av_d   = av_q;
    ps_d   = 1'b0;
    ls_d   = 1'b0;
    fs_d   = 1'b0;
    if (Enable) begin
      div_d = step ? '0 : div_q + DW'(1);
    end
    if (step) begin
      h_d = h_wrap ? '0 : h_q + CW'(1);
      if (h_wrap) begin
        v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
      end
      // Decodes look at the counters being loaded, not the ones being left.
      hs_d = ((32'(h_d) >= H_SS) && (32'(h_d) < H_SE)) ? HSYNC_POL : ~HSYNC_POL;
      vs_d = ((32'(v_d) >= V_SS) && (32'(v_d) < V_SE)) ? VSYNC_POL : ~VSYNC_POL;
      av_d = (32'(h_d) < H_ACTIVE) && (32'(v_d) < V_ACTIVE);
      ps_d = 1'b1;
      ls_d = (h_d == '0);
      fs_d = (h_d == '0) && (v_d == '0);
    end
  end

  // Counters park on the last raster position so the first step lands on (0,0).
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      div_q <= '0;
      h_q   <= H_LAST;
      v_q   <= V_LAST;
      hs_q  <= ~HSYNC_POL;
      vs_q  <= ~VSYNC_POL;
      av_q  <= 1'b0;
      ps_q  <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      av_q  <= av_d;
      ps_q  <= ps_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

  assign HorizontalSync    = hs_q;
  assign VerticalSync      = vs_q;
  assign HorizontalCounter = h_q;
  assign VerticalCounter   = v_q;
  assign ActiveVideo       = av_q;
  assign PixelStrobe       = ps_q;
  assign LineStart         = ls_q;
  assign FrameStart        = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameterisations checked every cycle against
// a raster model derived from the count of enabled clock edges since reset.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic        hs;
    logic        vs;
    logic        av;
    logic        ps;
    logic        ls;
    logic        fs;
  } vga_t;

  typedef struct {
    int ha, hf, hsn, hb;
    int va, vf, vsn, vb;
    int div;
    bit hp, vp;
  } cfg_t;

  cfg_t cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, 1'b0};
  cfg_t cfg_b = '{8, 1, 2, 1, 4, 1, 1, 1, 1, 1'b1, 1'b0};
  cfg_t cfg_c = '{5, 0, 2, 0, 3, 0, 1, 0, 3, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst_n;
  logic en_a, en_b, en_c;

  logic       a_hs, a_vs, a_av, a_ps, a_ls, a_fs;
  logic [9:0] a_h, a_v;
  logic       b_hs, b_vs, b_av, b_ps, b_ls, b_fs;
  logic [3:0] b_h, b_v;
  logic       c_hs, c_vs, c_av, c_ps, c_ls, c_fs;
  logic [2:0] c_h, c_v;

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_a   = 1'b0;
  bit rand_bc  = 1'b0;

  longint cnt_a, cnt_b, cnt_c;
  bit     st_a, st_b, st_c;

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .Clock(clk), .Reset(rst_n), .Enable(en_a),
    .HorizontalSync(a_hs), .VerticalSync(a_vs),
    .HorizontalCounter(a_h), .VerticalCounter(a_v),
    .ActiveVideo(a_av), .PixelStrobe(a_ps), .LineStart(a_ls), .FrameStart(a_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CLK_DIV(1), .CW(4)
  ) dut_b (
    .Clock(clk), .Reset(rst_n), .Enable(en_b),
    .HorizontalSync(b_hs), .VerticalSync(b_vs),
    .HorizontalCounter(b_h), .VerticalCounter(b_v),
    .ActiveVideo(b_av), .PixelStrobe(b_ps), .LineStart(b_ls), .FrameStart(b_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(5), .H_FRONT(0), .H_SYNC(2), .H_BACK(0),
    .V_ACTIVE(3), .V_FRONT(0), .V_SYNC(1), .V_BACK(0),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .CLK_DIV(3), .CW(3)
  ) dut_c (
    .Clock(clk), .Reset(rst_n), .Enable(en_c),
    .HorizontalSync(c_hs), .VerticalSync(c_vs),
    .HorizontalCounter(c_h), .VerticalCounter(c_v),
    .ActiveVideo(c_av), .PixelStrobe(c_ps), .LineStart(c_ls), .FrameStart(c_fs)
  );

  // Pixel p (1-based) after reset sits at raster position (p-1) mod H_TOTAL*V_TOTAL.
  function automatic vga_t model(cfg_t c, longint cnt, bit step);
    vga_t   r;
    longint p, pos;
    int     ht, vt, h, v;
    ht = c.ha + c.hf + c.hsn + c.hb;
    vt = c.va + c.vf + c.vsn + c.vb;
    r  = '0;
    p  = cnt / c.div;
    if (p == 0) begin
      r.h  = 16'(ht - 1);
      r.v  = 16'(vt - 1);
      r.hs = ~c.hp;
      r.vs = ~c.vp;
    end else begin
      pos  = (p - 1) % (ht * vt);
      h    = int'(pos % ht);
      v    = int'(pos / ht);
      r.h  = 16'(h);
      r.v  = 16'(v);
      r.hs = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hsn) ? c.hp : ~c.hp;
      r.vs = (v >= c.va + c.vf && v < c.va + c.vf + c.vsn) ? c.vp : ~c.vp;
      r.av = (h < c.ha) && (v < c.va);
      r.ps = step;
      r.ls = step && (h == 0);
      r.fs = step && (h == 0) && (v == 0);
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= 0; cnt_b <= 0; cnt_c <= 0;
      st_a  <= 1'b0; st_b <= 1'b0; st_c <= 1'b0;
    end else begin
      cnt_a <= cnt_a + (en_a ? 1 : 0);
      cnt_b <= cnt_b + (en_b ? 1 : 0);
      cnt_c <= cnt_c + (en_c ? 1 : 0);
      st_a  <= en_a && ((cnt_a + 1) % cfg_a.div == 0);
      st_b  <= en_b && ((cnt_b + 1) % cfg_b.div == 0);
      st_c  <= en_c && ((cnt_c + 1) % cfg_c.div == 0);
    end
  end

  task automatic cmp_vga(string name, vga_t act, vga_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got h=%0d v=%0d hs/vs/av/ps/ls/fs=%b%b%b%b%b%b, want h=%0d v=%0d hs/vs/av/ps/ls/fs=%b%b%b%b%b%b",
               name, $time, act.h, act.v, act.hs, act.vs, act.av, act.ps, act.ls, act.fs,
               exp.h, exp.v, exp.hs, exp.vs, exp.av, exp.ps, exp.ls, exp.fs);
    end
  endtask

  task automatic chk(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cmp_vga("model_a", {16'(a_h), 16'(a_v), a_hs, a_vs, a_av, a_ps, a_ls, a_fs}, model(cfg_a, cnt_a, st_a));
    cmp_vga("model_b", {16'(b_h), 16'(b_v), b_hs, b_vs, b_av, b_ps, b_ls, b_fs}, model(cfg_b, cnt_b, st_b));
    cmp_vga("model_c", {16'(c_h), 16'(c_v), c_hs, c_vs, c_av, c_ps, c_ls, c_fs}, model(cfg_c, cnt_c, st_c));
  end

  task automatic tick();
    @(negedge clk);
    if (rand_a) en_a = ($urandom_range(0, 3) != 0);
    if (rand_bc) begin
      en_b = ($urandom_range(0, 3) != 0);
      en_c = ($urandom_range(0, 2) != 0);
    end
  endtask

  initial begin
    int a_ls_t[$], b_ls_t[$], b_fs_t[$];
    int a_hs_lo, a_av_hi, b_hs_hi, b_vs_lo;
    bit found, frozen_ok;

    rst_n = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;

    // Free-running measurement window: strobe spacing and sync/active widths.
    a_hs_lo = 0; a_av_hi = 0; b_hs_hi = 0; b_vs_lo = 0;
    for (int k = 0; k < 3300; k++) begin
      tick();
      if (k == 0) begin
        chk("reset_h_a", a_h, 799);
        chk("reset_ps_a", a_ps, 0);
      end
      if (k == 1) begin
        chk("first_edge_no_ps_a", a_ps, 0);
        chk("first_edge_fs_b", b_fs, 1);
      end
      if (k == 2) begin
        chk("first_step_flags_a", {a_ps, a_ls, a_fs, a_av, a_hs, a_vs}, 6'b111111);
        chk("first_step_hv_a", {a_h, a_v}, 0);
      end
      if (a_ls) a_ls_t.push_back(k);
      if (b_ls) b_ls_t.push_back(k);
      if (b_fs) b_fs_t.push_back(k);
      if (a_ls_t.size() == 1) begin
        if (!a_hs) a_hs_lo++;
        if (a_av) a_av_hi++;
      end
      if (b_fs_t.size() == 1) begin
        if (b_hs) b_hs_hi++;
        if (!b_vs) b_vs_lo++;
      end
    end
    chk("a_first_ls_cycle", (a_ls_t.size() > 0) ? a_ls_t[0] : -1, 2);
    chk("a_line_period", (a_ls_t.size() > 1) ? a_ls_t[1] - a_ls_t[0] : -1, 1600);
    chk("a_hsync_low_cycles", a_hs_lo, 192);
    chk("a_active_cycles", a_av_hi, 1280);
    chk("b_line_period", (b_ls_t.size() > 1) ? b_ls_t[1] - b_ls_t[0] : -1, 12);
    chk("b_frame_period", (b_fs_t.size() > 1) ? b_fs_t[1] - b_fs_t[0] : -1, 84);
    chk("b_frame_period2", (b_fs_t.size() > 2) ? b_fs_t[2] - b_fs_t[1] : -1, 84);
    chk("b_hsync_high_cycles", b_hs_hi, 14);
    chk("b_vsync_low_cycles", b_vs_lo, 12);

    // Freeze at (100,5) right on its pixel step.
    rand_bc = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 12000 && !found; k++) begin
      tick();
      if (a_h == 100 && a_v == 5 && a_ps) found = 1'b1;
    end
    chk("wait_100_5_timeout", found, 1);
    en_a = 1'b0;
    frozen_ok = 1'b1;
    repeat (37) begin
      tick();
      if (!(a_h == 100 && a_v == 5 && !a_ps && !a_ls && !a_fs && a_av && a_hs && a_vs)) frozen_ok = 1'b0;
    end
    chk("freeze_hold", frozen_ok, 1);
    en_a = 1'b1;
    tick();
    chk("resume_no_early_step", {a_ps, 10'(a_h)}, {1'b0, 10'd100});
    tick();
    chk("resume_h101", {a_ps, 10'(a_h)}, {1'b1, 10'd101});
    tick();
    tick();
    chk("resume_h102", {a_ps, 10'(a_h)}, {1'b1, 10'd102});

    rand_a = 1'b1;
    repeat (20000) tick();
    rand_a = 1'b0;
    en_a = 1'b1;

    // Asynchronous reset mid-line, between clock edges.
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      tick();
      if (a_h == 700) found = 1'b1;
    end
    chk("wait_h700_timeout", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_hv_a", {a_h, a_v}, {10'd799, 10'd524});
    chk("async_rst_flags_a", {a_hs, a_vs, a_av, a_ps, a_ls, a_fs}, 6'b110000);
    chk("async_rst_b", {b_h, b_v, b_hs, b_vs}, {4'd11, 4'd6, 1'b0, 1'b1});
    repeat (3) tick();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("post_rst_first_step_a", {a_fs, a_ls, a_ps, a_h, a_v}, {3'b111, 20'd0});
    repeat (200) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
